z_m_seq_sub: RTL

Z_M_SEQ_SUB -- requirements
Module: z_m_seq_sub

---
 rtl/z_m_seq_sub.sv | 104 ++++++++++
 1 files changed

// File: rtl/z_m_seq_sub.sv
// Serial subtractor: a - b - b_in, M bits per clock; optional ovf output under Z_M_SEQ_SUB_OVF_EN.
// Latency N/M+1 clocks from the start sample to the one-cycle done pulse.
// No backpressure: start is taken only in IDLE/DONE and ignored while busy.
module z_m_seq_sub #(
  parameter int M = 4,
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         b_in,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] diff,
`ifdef Z_M_SEQ_SUB_OVF_EN
  output logic         b_out,
  output logic         ovf
`else
  output logic         b_out
`endif
);

  localparam int S  = N / M;
  localparam int KW = (S > 1) ? $clog2(S) : 1;
  localparam logic [KW-1:0] LAST = KW'(S - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [KW-1:0] k;
  logic          borrow;
  logic [N-1:0]  a_q, b_q, diff_q;
  logic          b_out_q;
  logic [M-1:0]  a_sl, b_sl;
  logic [M:0]    sub;
  int unsigned   base;

  // Current slice difference; the extra MSB of sub is the slice borrow-out.
  always_comb begin
    base = 32'(k) * 32'(M);
    a_sl = a_q[base +: M];
    b_sl = b_q[base +: M];
    sub  = {1'b0, a_sl} - {1'b0, b_sl} - {{M{1'b0}}, borrow};
  end

`ifdef Z_M_SEQ_SUB_OVF_EN
  logic ovf_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (state == RUN && k == LAST) begin
      ovf_q <= (a_q[N-1] ^ b_q[N-1]) & (a_q[N-1] ^ sub[M-1]);
    end
  end
  assign ovf = ovf_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      k       <= '0;
      borrow  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      b_out_q <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_q    <= a;
            b_q    <= b;
            borrow <= b_in;
            k      <= '0;
            state  <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          diff_q[base +: M] <= sub[M-1:0];
          borrow            <= sub[M];
          if (k == LAST) begin
            b_out_q <= sub[M];
            state   <= DONE;
          end else begin
            k <= k + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy  = (state == RUN);
  assign done  = (state == DONE);
  assign diff  = diff_q;
  assign b_out = b_out_q;

endmodule
